// File: rtl/add16_mp_seq_if.sv
// Request/result bundle between a wide-add requester and the multi-precision adder sequencer.
interface add16_mp_seq_if #(
   parameter int WORDS = 4
);
   logic                  start;
   logic [16*WORDS-1:0]   A;
   logic [16*WORDS-1:0]   B;
   logic                  Cin;
   logic                  busy;
   logic                  done;
   logic [16*WORDS-1:0]   Sum;
   logic                  Cout;

   modport master (
      output start, A, B, Cin,
      input  busy, done, Sum, Cout
   );

   modport slave (
      input  start, A, B, Cin,
      output busy, done, Sum, Cout
   );
endinterface

// File: rtl/add16_mp_seq.sv
// Wide unsigned adder that reuses one 16-bit adder, one word per cycle, LS word first.
// state | meaning
// IDLE  | waiting for start; Sum/Cout hold last result
// RUN   | one word added per cycle, carry kept in c
// DONE  | single-cycle done pulse, then back to IDLE

module add16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {16'd0, ci};
endmodule

module add16_mp_seq #(
   parameter int WORDS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   add16_mp_seq_if.slave     bus
);
   localparam int IW = $clog2(WORDS);
   localparam int N  = 16 * WORDS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx;
   logic              c;
   logic [N-1:0]      a_q, b_q;
   logic [N-1:0]      sum_q;
   logic              cout_q;
   logic [IW+3:0]     lsb;
   logic [15:0]       add_s;
   logic              add_co;
   logic              last_word;

   assign lsb       = {idx, 4'b0000};
   assign last_word = (idx == IW'(WORDS - 1));

   add16 u_add16 (
      .a  (a_q[lsb +: 16]),
      .b  (b_q[lsb +: 16]),
      .ci (c),
      .s  (add_s),
      .co (add_co)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last_word) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operands are only captured in IDLE, so start during RUN/DONE cannot disturb them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx    <= '0;
         c      <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q <= bus.A;
                  b_q <= bus.B;
                  c   <= bus.Cin;
                  idx <= '0;
               end
            end
            RUN: begin
               sum_q[lsb +: 16] <= add_s;
               c                <= add_co;
               if (last_word) begin
                  cout_q <= add_co;
                  idx    <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;
endmodule

// File: tb/tb_add16_mp_seq.sv
// Directed and random checks of the word-serial wide adder against plain wide arithmetic.
module tb_add16_mp_seq;
   localparam int WORDS = 4;
   localparam int N     = 16 * WORDS;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   cyc;

   add16_mp_seq_if #(.WORDS(WORDS)) bus ();

   add16_mp_seq #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
      return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
   endfunction

   function automatic logic [N-1:0] rnd_word();
      logic [N-1:0] v;
      for (int i = 0; i < WORDS; i++) v[16*i +: 16] = 16'($urandom);
      return v;
   endfunction

   // Issues one operation from IDLE and checks handshake timing plus result; returns done cycle.
   task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, output int done_cyc);
      int busy_cnt;
      int done_cnt;
      logic [N:0] exp;
      exp      = ref_add(a, b, ci);
      busy_cnt = 0;
      done_cnt = 0;
      bus.A    = a;
      bus.B    = b;
      bus.Cin  = ci;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.A    = rnd_word();
      bus.B    = rnd_word();
      bus.Cin  = 1'b1;
      for (int i = 0; i < WORDS; i++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) done_cnt++;
         tick();
      end
      check({tag, ".busy_cycles"}, (N+1)'(busy_cnt), (N+1)'(WORDS));
      check({tag, ".early_done"}, (N+1)'(done_cnt), '0);
      check({tag, ".done"}, (N+1)'({bus.done, bus.busy}), (N+1)'(2'b10));
      check({tag, ".result"}, {bus.Cout, bus.Sum}, exp);
      done_cyc = cyc;
      tick();
      check({tag, ".idle_hold"}, {bus.Cout, bus.Sum, bus.busy, bus.done}, (N+3)'({exp, 2'b00}));
   endtask

   initial begin
      int t1, t2, dcnt;
      logic [N-1:0] a0, b0;
      logic [N:0] exp0;
      logic [N:0] seen;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.Cin = 1'b0;
      tick();
      tick();
      check("reset_state", {1'b0, bus.busy, bus.done, bus.Cout, bus.Sum[N-2:0]}, '0);
      check("reset_sum", {bus.Cout, bus.Sum}, '0);
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", (N+1)'({bus.busy, bus.done}), '0);

      do_op("carry_word", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, t1);
      check("carry_word.lit", {bus.Cout, bus.Sum}, {1'b0, 64'h0000_0000_0001_0000});
      do_op("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, t1);
      check("full_carry.lit", {bus.Cout, bus.Sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
      do_op("cin_prop", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, t1);
      check("cin_prop.lit", {bus.Cout, bus.Sum}, {1'b0, 64'h0} | (65'b1 << 64));
      do_op("mixed", 64'h0000_0202_7700_0202, 64'h0000_00FF_0000_0003, 1'b0, t1);
      check("mixed.lit", {bus.Cout, bus.Sum}, {1'b0, 64'h0000_0301_7700_0205});

      // start held high with fresh operands through RUN and DONE
      a0 = rnd_word();
      b0 = rnd_word();
      exp0 = ref_add(a0, b0, 1'b1);
      bus.A = a0;
      bus.B = b0;
      bus.Cin = 1'b1;
      bus.start = 1'b1;
      tick();
      dcnt = 0;
      seen = '0;
      for (int j = 0; j <= WORDS; j++) begin
         if (bus.done === 1'b1) begin
            dcnt++;
            seen = {bus.Cout, bus.Sum};
         end
         bus.A = rnd_word();
         bus.B = rnd_word();
         bus.Cin = 1'($urandom);
         tick();
      end
      bus.start = 1'b0;
      check("hs.done_count", (N+1)'(dcnt), (N+1)'(1));
      check("hs.result", seen, exp0);
      check("hs.not_reaccepted", (N+1)'({bus.busy, bus.done}), '0);
      tick();
      check("hs.idle_hold", {bus.Cout, bus.Sum}, exp0);

      // reset during the second RUN cycle
      bus.A = rnd_word();
      bus.B = rnd_word();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_mid.outputs", {bus.Cout, bus.Sum}, '0);
      check("rst_mid.flags", (N+1)'({bus.busy, bus.done}), '0);
      dcnt = 0;
      for (int j = 0; j < 2 * WORDS; j++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
         tick();
      end
      check("rst_mid.no_done", (N+1)'(dcnt), '0);
      do_op("after_rst", 64'h1, 64'h1, 1'b0, t1);
      check("after_rst.lit", {bus.Cout, bus.Sum}, 65'h2);

      do_op("b2b_first", rnd_word(), rnd_word(), 1'b0, t1);
      do_op("b2b_second", rnd_word(), rnd_word(), 1'b1, t2);
      check("b2b.spacing", (N+1)'(t2 - t1), (N+1)'(WORDS + 2));

      for (int r = 0; r < 6; r++) begin
         do_op($sformatf("rand%0d", r), rnd_word(), rnd_word(), 1'($urandom), t1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
